// File: rtl/bundle_threshold_unit.sv
// bundle_threshold_unit
// Consumes the pipelined adder tree output: a delay line tracks the tree
// latency, per-chunk sums are accumulated over a vector, and the total is
// compared against a threshold to yield one bundling bit per vector.
// Optional feature macro: ACC_SATURATE_EN (clamp accumulator instead of wrap).
//
// Handshake: result_valid/result_ready follow valid/ready semantics. A result
// transfers on any rising edge where both are high. result_valid stays high
// and the result fields stay stable until that transfer. A new result may load
// in the same edge as a transfer. A result that arrives while the register is
// full and not being drained is dropped, and sets the sticky overrun flag.
module bundle_threshold_unit #(
  parameter int INPUT_WIDTH  = 8,
  parameter int ACC_WIDTH    = 16,
  parameter int TREE_LATENCY = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   issue_valid,
  input  logic                   issue_last,
  input  logic [INPUT_WIDTH-1:0] tree_sum,
  input  logic [ACC_WIDTH-1:0]   threshold,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   result_bit,
  output logic [ACC_WIDTH-1:0]   result_sum,
  output logic [CNT_WIDTH-1:0]   result_chunks,
  output logic                   overrun,
  output logic                   saturated,
  output logic                   dbg_state
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_e;

  // Delay line (valid and last travel alongside the tree)
  logic [TREE_LATENCY-1:0] dv_q, dv_d;
  logic [TREE_LATENCY-1:0] dl_q, dl_d;
  logic                    a_valid;
  logic                    a_last;

  // Accumulation state
  state_e                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  // Output register and sticky flags
  logic                    rv_q, rv_d;
  logic                    rbit_q, rbit_d;
  logic [ACC_WIDTH-1:0]    rsum_q, rsum_d;
  logic [CNT_WIDTH-1:0]    rcnt_q, rcnt_d;
  logic                    ovr_q, ovr_d;
  logic                    sat_q, sat_d;

  // Datapath intermediates
  logic [ACC_WIDTH-1:0]    acc_base;
  logic [CNT_WIDTH-1:0]    cnt_base;
  logic [ACC_WIDTH:0]      sum_wide;
  logic [ACC_WIDTH-1:0]    acc_next;
  logic [CNT_WIDTH-1:0]    cnt_next;
  logic                    clip;
  logic                    new_res;
  logic                    can_load;

  assign a_valid = dv_q[TREE_LATENCY-1];
  assign a_last  = dl_q[TREE_LATENCY-1];

  // Shift the issue qualifiers one stage per cycle
  always_comb begin
    dv_d    = '0;
    dl_d    = '0;
    dv_d[0] = issue_valid;
    dl_d[0] = issue_valid & issue_last;
    for (int i = 1; i < TREE_LATENCY; i++) begin
      dv_d[i] = dv_q[i-1];
      dl_d[i] = dl_q[i-1];
    end
  end

  // Accumulator add: a fresh vector starts from zero, otherwise extend acc
  always_comb begin
    acc_base = (state_q == S_ACCUM) ? acc_q : '0;
    cnt_base = (state_q == S_ACCUM) ? cnt_q : '0;
    sum_wide = {1'b0, acc_base} + {{(ACC_WIDTH + 1 - INPUT_WIDTH){1'b0}}, tree_sum};
    cnt_next = cnt_base + CNT_WIDTH'(1);
`ifdef ACC_SATURATE_EN
    clip     = sum_wide[ACC_WIDTH];
    acc_next = clip ? '1 : sum_wide[ACC_WIDTH-1:0];
`else
    clip     = 1'b0;
    acc_next = sum_wide[ACC_WIDTH-1:0];
`endif
  end

  // Next-state: FSM, accumulator and output register
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rv_d     = rv_q;
    rbit_d   = rbit_q;
    rsum_d   = rsum_q;
    rcnt_d   = rcnt_q;
    ovr_d    = ovr_q;
    sat_d    = sat_q | (a_valid & clip);
    new_res  = a_valid & a_last;
    can_load = ~rv_q | result_ready;

    if (a_valid) begin
      if (a_last) begin
        state_d = S_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = S_ACCUM;
        acc_d   = acc_next;
        cnt_d   = cnt_next;
      end
    end

    if (new_res && can_load) begin
      rv_d   = 1'b1;
      rbit_d = (acc_next > threshold);
      rsum_d = acc_next;
      rcnt_d = cnt_next;
    end else if (new_res) begin
      ovr_d  = 1'b1;
    end else if (rv_q && result_ready) begin
      rv_d   = 1'b0;
    end
  end

  // Delay line register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q <= '0;
      dl_q <= '0;
    end else if (clear) begin
      dv_q <= '0;
      dl_q <= '0;
    end else begin
      dv_q <= dv_d;
      dl_q <= dl_d;
    end
  end

  // FSM state, accumulator, result register and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rbit_q  <= 1'b0;
      rsum_q  <= '0;
      rcnt_q  <= '0;
      ovr_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else if (clear) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rbit_q  <= 1'b0;
      rsum_q  <= '0;
      rcnt_q  <= '0;
      ovr_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rbit_q  <= rbit_d;
      rsum_q  <= rsum_d;
      rcnt_q  <= rcnt_d;
      ovr_q   <= ovr_d;
      sat_q   <= sat_d;
    end
  end

  assign result_valid  = rv_q;
  assign result_bit    = rbit_q;
  assign result_sum    = rsum_q;
  assign result_chunks = rcnt_q;
  assign overrun       = ovr_q;
  assign saturated     = sat_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/bundle_threshold_unit.md
# bundle_threshold_unit

Downstream consumer of the pipelined 16-input adder tree in the HD accelerator datapath. Tracks the tree's fixed latency with an internal valid/last delay line, accumulates per-chunk tree sums across a multi-chunk hypervector segment, and compares the total against a programmable threshold to produce one binarized bundling bit per vector. The result is held in a one-entry output register with a valid/ready handshake.

## Interface
- INPUT_WIDTH, 8, width of tree_sum.
- ACC_WIDTH, 16, accumulator, threshold and result_sum width; must be at least INPUT_WIDTH.
- TREE_LATENCY, 4, cycles from presenting inputs to the tree until its out reflects them.
- CNT_WIDTH, 8, chunk counter width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of all state; has priority over all other inputs.
- issue_valid  in  1  high in the cycle a chunk is presented to the adder tree inputs.
- issue_last  in  1  qualifies issue_valid; marks the final chunk of a vector.
- tree_sum  in  INPUT_WIDTH  adder tree out, sampled combinationally.
- threshold  in  ACC_WIDTH  compare value; sampled in the cycle the last chunk aligns.
- result_valid  out  1  result register holds an unconsumed result.
- result_ready  in  1  consumer accepts the result when result_valid is also high.
- result_bit  out  1  1 iff result_sum > threshold (strict).
- result_sum  out  ACC_WIDTH  final accumulated sum.
- result_chunks  out  CNT_WIDTH  number of chunks in the vector.
- overrun  out  1  sticky: a result was dropped because the output register was full.
- saturated  out  1  sticky: the accumulator clipped during any vector.

## Operation
- Delay line: TREE_LATENCY-stage shift register of {issue_valid, issue_last}. Aligned pair a_valid/a_last is the last stage; tree_sum is sampled in the cycle a_valid is high.
- State machine with two states. IDLE: no partial vector. ACCUM: partial vector in acc/cnt.
- a_valid in IDLE: acc_next = zext(tree_sum), cnt_next = 1. a_valid in ACCUM: acc_next = acc + zext(tree_sum), cnt_next = cnt + 1 (counter wraps modulo 2^CNT_WIDTH).
- a_valid && !a_last: acc <= acc_next, cnt <= cnt_next, go to ACCUM.
- a_valid && a_last: compute result from acc_next/cnt_next and threshold; acc, cnt <= 0; go to IDLE. Back-to-back vectors (last followed immediately by a new chunk) at full rate.
- No a_valid: state, acc, cnt hold.
- Output register: result loads if !result_valid or (result_valid && result_ready) in the same cycle; otherwise new result is dropped, old retained, overrun <= 1.
- result_valid clears on handshake with no new result.
- Sticky flags clear only on reset or clear.
- clear: delay line, state, acc, cnt, result_valid, result fields, flags all zeroed next edge; in-flight chunks lost.

## Timing
- Reset values: result_valid 0, result_bit 0, result_sum 0, result_chunks 0, overrun 0, saturated 0; state IDLE, delay line empty.
- issue_valid in cycle t -> tree_sum consumed in cycle t+TREE_LATENCY -> result_valid high from cycle t+TREE_LATENCY+1.
- Throughput: one chunk per cycle; no input stall exists (tree cannot stall).
- Reset asserted mid-vector: all state cleared immediately; chunks already in the tree are discarded because the delay line is emptied.

## Configuration
- ACC_SATURATE_EN defined: accumulator addition clamps at 2^ACC_WIDTH-1 and sets saturated.
- Undefined: addition wraps modulo 2^ACC_WIDTH; saturated tied to 0.

## Test plan
- Single chunk: issue_valid=issue_last=1 at cycle 0, tree_sum=123 at cycle 4, threshold=100 -> cycle 5 result_valid=1, sum 123, bit 1, chunks 1.
- Three chunks: sums 123, 163, 99 on consecutive aligned cycles; threshold 400 -> sum 385, bit 0, chunks 3; repeat with threshold 384 -> bit 1, with 385 -> bit 0.
- Backpressure: result_ready=0, two single-chunk vectors (123 then 50) -> result_sum stays 123, overrun=1; ready=1 -> valid drops next cycle.
- Simultaneous handshake and new result: result_valid=1, ready=1 as vector 50 completes -> result_sum=50, result_valid stays 1, overrun=0.
- ACC_WIDTH=8, sums 200+100: with ACC_SATURATE_EN -> 255, saturated=1; without -> 44, saturated=0.
- rst_n low after two chunks of a three-chunk vector -> all outputs 0; next single chunk 7 -> result_sum 7, chunks 1.
